// File: rtl/core_pkg.sv
// Shared encodings for the core sequencer: FSM states, control opcodes,
// branch condition codes, CPSR flag bit positions and the branch-target helper.
// Latency/backpressure: n/a (declarations only).
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_FETCH  = 3'b001,
        ST_DECODE = 3'b010,
        ST_EXEC   = 3'b011,
        ST_WB     = 3'b100,
        ST_HALT   = 3'b101
    } state_t;

    // alu_oc meanings for control-class instructions
    localparam logic [2:0] ALU_OC_JMP  = 3'b000;
    localparam logic [2:0] ALU_OC_BCC  = 3'b001;
    localparam logic [2:0] ALU_OC_HALT = 3'b111;

    // first_ld value that marks a data-class instruction
    localparam logic [1:0] FIRST_LD_DATA = 2'b00;

    // b_cond codes
    localparam logic [3:0] BC_EQ = 4'b0000;
    localparam logic [3:0] BC_NE = 4'b0001;
    localparam logic [3:0] BC_CS = 4'b0010;
    localparam logic [3:0] BC_CC = 4'b0011;
    localparam logic [3:0] BC_MI = 4'b0100;
    localparam logic [3:0] BC_PL = 4'b0101;
    localparam logic [3:0] BC_VS = 4'b0110;
    localparam logic [3:0] BC_VC = 4'b0111;
    localparam logic [3:0] BC_HI = 4'b1000;
    localparam logic [3:0] BC_LS = 4'b1001;
    localparam logic [3:0] BC_GE = 4'b1010;
    localparam logic [3:0] BC_LT = 4'b1011;
    localparam logic [3:0] BC_GT = 4'b1100;
    localparam logic [3:0] BC_LE = 4'b1101;
    localparam logic [3:0] BC_AL = 4'b1110;
    localparam logic [3:0] BC_NV = 4'b1111;

    // CPSR flag bit indices within {N,C,Z,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    // Word offset relative to the branch's own address, wraps modulo 2^32
    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic [15:0] word_off);
        return base + {{14{word_off[15]}}, word_off, 2'b00};
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: maps b_cond and registered {N,C,Z,V} to taken.
// Latency: purely combinational. Backpressure: none.
// Ports: b_cond[3:0] condition code, flags[3:0] CPSR, taken = condition holds.
module branch_cond_eval
    import core_pkg::*;
(
    input  logic [3:0] b_cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, c, z, v;

    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (b_cond)
            BC_EQ: taken = z;
            BC_NE: taken = !z;
            BC_CS: taken = c;
            BC_CC: taken = !c;
            BC_MI: taken = n;
            BC_PL: taken = !n;
            BC_VS: taken = v;
            BC_VC: taken = !v;
            BC_HI: taken = c && !z;
            BC_LS: taken = !(c && !z);
            BC_GE: taken = (n == v);
            BC_LT: taken = (n != v);
            BC_GT: taken = !z && (n == v);
            BC_LE: taken = !(!z && (n == v));
            BC_AL: taken = 1'b1;
            BC_NV: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle core sequencer: FETCH -> DECODE -> EXEC -> (WB) with branch/halt.
// Latency: ALU/data 4 cycles, control 3 cycles with zero-wait fetch.
// Backpressure: FETCH holds imem_req/imem_addr stable until imem_ack.
// Ports: imem_* fetch handshake; instr latched word; decoded fields in;
// alu_flags from EX; flags/pc/state registered; rf_we/rf_wsel to register file.
module core_sequencer
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        special_encoding,
    input  logic [1:0]  first_ld,
    input  logic [2:0]  alu_oc,
    input  logic [3:0]  b_cond,
    input  logic [15:0] offset,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  flags,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic [31:0] pc,
    output logic [2:0]  state
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [3:0]  flags_q, flags_d;
    logic        run_q;
    logic        cond_taken;

    // Conditions always look at the registered flags, never at alu_flags
    branch_cond_eval u_cond (
        .b_cond (b_cond),
        .flags  (flags_q),
        .taken  (cond_taken)
    );

    // run_q stays low for the first edge after reset release so that IDLE
    // spans one full cycle and FETCH starts on the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            flags_q <= 4'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            flags_q <= flags_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (run_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (special_encoding) begin
                    flags_d = alu_flags;
                    state_d = ST_WB;
                end else if (first_ld == FIRST_LD_DATA) begin
                    state_d = ST_WB;
                end else begin
                    // Control class: pc moves here, no write-back
                    state_d = ST_FETCH;
                    case (alu_oc)
                        ALU_OC_JMP:  pc_d = branch_target(pc_q, offset);
                        ALU_OC_BCC:  pc_d = cond_taken ? branch_target(pc_q, offset)
                                                       : pc_q + 32'd4;
                        ALU_OC_HALT: state_d = ST_HALT;
                        default:     pc_d = pc_q + 32'd4;
                    endcase
                end
            end
            ST_WB: begin
                pc_d    = pc_q + 32'd4;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign rf_we     = (state_q == ST_WB);
    assign rf_wsel   = !special_encoding;
    assign instr     = instr_q;
    assign flags     = flags_q;
    assign pc        = pc_q;
    assign state     = state_q;

endmodule
